// File: rtl/rr_lock_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arbiter_if
// Description : Request/grant bundle between N requesters and the
//               rr_lock_arbiter that owns the shared resource.
//               master : requester/resource side (drives req_i, done_i)
//               slave  : arbiter side (drives gnt_o, gnt_id_o, busy_o,
//                        timeout_o)
//   req_i     [N]   level request per port
//   done_i    [1]   current owner's transaction complete
//   gnt_o     [N]   one-hot registered grant
//   gnt_id_o  [IDW] index of the granted port, 0 when idle
//   busy_o    [1]   any grant active
//   timeout_o [1]   one-cycle pulse when a grant is revoked by the budget
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_lock_arbiter_if #(
   parameter int N = 4
);
   localparam int IDW = $clog2(N);

   logic [N-1:0]   req_i;
   logic           done_i;
   logic [N-1:0]   gnt_o;
   logic [IDW-1:0] gnt_id_o;
   logic           busy_o;
   logic           timeout_o;

   modport master (
      output req_i, done_i,
      input  gnt_o, gnt_id_o, busy_o, timeout_o
   );

   modport slave (
      input  req_i, done_i,
      output gnt_o, gnt_id_o, busy_o, timeout_o
   );
endinterface
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arbiter
// Description : Multi-cycle round-robin arbiter. A grant is held until the
//               owner signals done, drops its request, or exhausts a hold
//               budget of MAX_HOLD cycles (0 = no budget). On release the
//               search pointer moves past the owner and a new winner is
//               granted in the same edge, so there is no idle bubble.
//   clk    [1]  rising-edge clock
//   reset  [1]  synchronous reset, active low
//   bus         rr_lock_arbiter_if.slave (req_i, done_i, gnt_o, gnt_id_o,
//               busy_o, timeout_o)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lock_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  wire logic        clk,
   input  wire logic        reset,
   rr_lock_arbiter_if.slave bus
);
   localparam int IDW = $clog2(N);
   localparam int HW  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam bit               BUDGET_EN = (MAX_HOLD != 0);
   localparam logic [HW-1:0]    HOLD_LAST = BUDGET_EN ? HW'(MAX_HOLD - 1) : '0;
   localparam logic [N-1:0]     ONE       = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [HW-1:0]   hold_cnt;
   logic [N-1:0]    gnt;
   logic [IDW-1:0]  gnt_id;
   logic            timeout;

   // Round-robin pick: rotate the request vector down by p using a
   // double-width copy, take the lowest set bit, and map back to a port.
   function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0]   r,
                                              input logic [IDW-1:0] p);
      logic [2*N-1:0] dbl;
      int             idx;
      dbl = {r, r} >> p;
      idx = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (dbl[i]) idx = (int'(p) + i) % N;
      end
      return IDW'(idx);
   endfunction

   logic            any_req;
   logic            owner_req;
   logic            expire;
   logic            release_now;
   logic [IDW-1:0]  next_ptr;
   logic [IDW-1:0]  win_idle;
   logic [IDW-1:0]  win_rel;

   always_comb begin
      any_req     = |bus.req_i;
      owner_req   = |(bus.req_i & gnt);
      expire      = BUDGET_EN && (hold_cnt == HOLD_LAST);
      release_now = bus.done_i || !owner_req || expire;
      next_ptr    = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
      win_idle    = rr_pick(bus.req_i, ptr);
      // Searching from owner+1 leaves the owner as the last candidate.
      win_rel     = rr_pick(bus.req_i, next_ptr);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_id   <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt      <= ONE << win_idle;
                  gnt_id   <= win_idle;
                  hold_cnt <= '0;
                  state    <= OWN;
               end
            end
            OWN: begin
               if (release_now) begin
                  ptr      <= next_ptr;
                  hold_cnt <= '0;
                  // Pulse only when the budget is the actual release cause.
                  timeout  <= expire && !bus.done_i && owner_req;
                  if (any_req) begin
                     gnt    <= ONE << win_rel;
                     gnt_id <= win_rel;
                  end else begin
                     gnt    <= '0;
                     gnt_id <= '0;
                     state  <= IDLE;
                  end
               end else if (hold_cnt != {HW{1'b1}}) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt_o     = gnt;
   assign bus.gnt_id_o  = gnt_id;
   assign bus.busy_o    = |gnt;
   assign bus.timeout_o = timeout;
endmodule
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_lock_arbiter
// Description : Directed self-checking bench for rr_lock_arbiter (N=4,
//               MAX_HOLD=8). Inputs change 1 ns after a rising edge and
//               outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_lock_arbiter;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   rr_lock_arbiter_if #(.N(4)) bus ();

   rr_lock_arbiter #(.N(4), .MAX_HOLD(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic to);
      chk({tag, ".gnt"}, 32'(bus.gnt_o), 32'(g));
      chk({tag, ".id"}, 32'(bus.gnt_id_o), 32'(id));
      chk({tag, ".busy"}, 32'(bus.busy_o), 32'(|g));
      chk({tag, ".timeout"}, 32'(bus.timeout_o), 32'(to));
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b0;
      bus.req_i   = 4'b0000;
      bus.done_i  = 1'b0;

      // Reset for two cycles, then a single requester on port 2.
      tick();
      tick();
      chk_state("reset", 4'b0000, 2'd0, 1'b0);
      reset     = 1'b1;
      bus.req_i = 4'b0100;
      tick();
      chk_state("single_grant", 4'b0100, 2'd2, 1'b0);
      tick();
      tick();
      chk_state("single_hold", 4'b0100, 2'd2, 1'b0);
      bus.done_i = 1'b1;
      bus.req_i  = 4'b0000;
      tick();
      chk_state("single_done", 4'b0000, 2'd0, 1'b0);
      // done_i with no grant active is ignored.
      tick();
      chk_state("done_idle", 4'b0000, 2'd0, 1'b0);
      bus.done_i = 1'b0;

      // Reset brings ptr back to 0; round robin over all four ports.
      reset = 1'b0;
      tick();
      reset     = 1'b1;
      bus.req_i = 4'b1111;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk_state($sformatf("rr_grant%0d", k), 4'(1 << k), 2'(k), 1'b0);
         tick();
         chk_state($sformatf("rr_hold%0d", k), 4'(1 << k), 2'(k), 1'b0);
         bus.done_i = 1'b1;
         tick();
         bus.done_i = 1'b0;
      end
      chk_state("rr_wrap", 4'b0001, 2'd0, 1'b0);

      // Hold budget: ports 0 and 1 alternate every 8 cycles.
      reset     = 1'b0;
      bus.req_i = 4'b0000;
      tick();
      reset     = 1'b1;
      bus.req_i = 4'b0011;
      tick();
      chk_state("to_grant0", 4'b0001, 2'd0, 1'b0);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk_state($sformatf("to_hold0_%0d", k), 4'b0001, 2'd0, 1'b0);
      end
      tick();
      chk_state("to_switch1", 4'b0010, 2'd1, 1'b1);
      tick();
      chk_state("to_pulse_end", 4'b0010, 2'd1, 1'b0);
      for (int k = 2; k < 8; k++) begin
         tick();
         chk("to_hold1.gnt", 32'(bus.gnt_o), 32'h2);
      end
      tick();
      chk_state("to_switch0", 4'b0001, 2'd0, 1'b1);

      // Port 0 abandons; only port 3 requests -> port 3 owns.
      bus.req_i = 4'b1000;
      tick();
      chk_state("ab_grant3", 4'b1000, 2'd3, 1'b0);
      // Non-owner request change does not disturb the grant.
      bus.req_i = 4'b1010;
      tick();
      chk_state("ab_nonowner", 4'b1000, 2'd3, 1'b0);
      // Port 3 drops: ptr=0, port 1 wins, no timeout.
      bus.req_i = 4'b0010;
      tick();
      chk_state("ab_switch1", 4'b0010, 2'd1, 1'b0);

      // done_i coincides with budget expiry: release, no timeout pulse.
      for (int k = 1; k < 8; k++) tick();
      chk_state("sim_before", 4'b0010, 2'd1, 1'b0);
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      chk_state("sim_release", 4'b0010, 2'd1, 1'b0);
      tick();
      chk_state("sim_after", 4'b0010, 2'd1, 1'b0);

      // Port 2 owns with hold_cnt=5, then reset for one cycle.
      bus.req_i = 4'b0100;
      tick();
      chk_state("mid_grant2", 4'b0100, 2'd2, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      chk_state("mid_hold5", 4'b0100, 2'd2, 1'b0);
      reset = 1'b0;
      tick();
      chk_state("mid_reset", 4'b0000, 2'd0, 1'b0);
      reset     = 1'b1;
      bus.req_i = 4'b0110;
      tick();
      chk_state("mid_after", 4'b0010, 2'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Multi-cycle round-robin arbiter: shares one resource between N requesters.
- A grant, once issued, is held until the owner signals completion, drops its request, or exceeds a hold budget.
- Sits in front of a shared datapath (bus port, memory bank) that fixed-priority single-cycle arbitration would starve.
- Registered one-hot grant plus owner index for downstream muxing.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_HOLD, 8, maximum cycles a grant may be held; 0 disables the timeout.
- IDW, $clog2(N), width of gnt_id_o (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous reset, active-low: state clears on a rising clk edge while reset==0.
- req_i  input  N  request per port, level; held while transaction pending.
- done_i  input  1  resource signals the current owner's transaction is complete; ignored when no grant is active.
- gnt_o  output  N  one-hot registered grant, all-zero when idle.
- gnt_id_o  output  IDW  index of the granted port; 0 when idle.
- busy_o  output  1  high while any grant is active (equals |gnt_o).
- timeout_o  output  1  one-cycle pulse in the cycle a grant is revoked by the hold budget.

Behaviour:
- Reset (reset==0 at edge):
  - gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0.
  - state=IDLE, ptr=0, hold_cnt=0.
  - A reset during ownership drops the grant at that edge. No done or timeout is reported.
- Arbitration function:
  - Winner is the first set bit of the candidate vector, searched from index ptr upward, wrapping N-1 to 0.
  - Implement as a double-width masked priority encode or equivalent.
  - Combinational from registered ptr; output effect registered.
- IDLE:
  - If req_i != 0 at an edge, then at that edge: gnt_o=onehot(winner), gnt_id_o=winner, hold_cnt=0, state=OWN.
  - Latency req to gnt is 1 cycle. Otherwise remain IDLE.
- OWN: each edge evaluates the release conditions for the owner o, in priority order:
  - (a) reset.
  - (b) done_i==1.
  - (c) req_i[o]==0 (owner abandoned).
  - (d) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (budget exhausted; timeout_o=1 for the next cycle).
  - If no condition holds: hold_cnt increments, grant unchanged.
- Release step, in the same edge as the release:
  - ptr <= (o+1) mod N.
  - Re-arbitrate immediately over current req_i using the new ptr. The owner is a candidate but lowest priority.
  - If there is a winner, the grant switches directly to it with no idle bubble, and hold_cnt=0.
  - If there is no winner, gnt_o=0 and state=IDLE.
- Simultaneous done_i and budget exhaustion: treated as done, no timeout_o pulse.
- gnt_o is never multi-hot. gnt_o changes only at clk edges. A req_i change on a non-owner port never disturbs the current grant.
- ptr advances only on release, never in IDLE, so an idle gap preserves fairness order.
- hold_cnt width is $clog2(MAX_HOLD+1) (min 1 bit). It saturates (does not wrap) when MAX_HOLD==0.
- timeout_o is registered; it is high for exactly one cycle, aligned with the first cycle of the post-release grant state.

Test Plan:
- Reset then single requester:
  - Stimulus: reset low 2 cycles; req_i=4'b0100 from cycle 3.
  - Response: gnt_o=0100, gnt_id_o=2 from cycle 4. Grant held until done_i pulse at cycle 7, then gnt_o=0 at cycle 8.
- Round-robin fairness:
  - Stimulus: req_i=4'b1111 constant; done_i pulsed every 3rd cycle.
  - Response: grant order 0,1,2,3,0 with no idle bubble between grants; no port granted twice before all others are served.
- Timeout (MAX_HOLD=8):
  - Stimulus: req_i=4'b0011, no done_i.
  - Response: port 0 holds exactly 8 cycles, then grant moves to port 1 and timeout_o is a single-cycle pulse; then port 1 holds 8 cycles, then port 0.
- Owner abandons:
  - Stimulus: port 3 granted; req_i[3] drops while req_i[1]=1.
  - Response: next cycle gnt_o=0010, ptr=0. No timeout_o.
- Simultaneous done_i and budget expiry on cycle MAX_HOLD:
  - Response: release proceeds, timeout_o stays 0.
- Reset mid-ownership:
  - Stimulus: port 2 owns with hold_cnt=5; reset low one cycle.
  - Response: gnt_o=0, busy_o=0 after that edge, ptr=0. With req_i=4'b0110 afterwards, port 1 is granted first.
